rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- Decode pipeline stage between instruction fetch and execute.
- Accepts a raw 32-bit RV32I instruction word and its PC from fetch over a valid/ready handshake.
- Decodes the word into register addresses, a sign-extended immediate, an ALU op, a write-enable and an illegal flag.
- Holds the result in a single pipeline register presented to execute over a valid/ready handshake. A synchronous flush input supports branch redirect.

Parameters:
- none (RV32I fixed: XLEN 32, 5-bit register addresses)

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of the held instruction; dropping any incoming one.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage can accept this cycle.
- if_pc  in  32  PC of the presented instruction.
- if_instr  in  32  raw instruction word.
- rf_rs1_addr  out  5  combinational instr[19:15] of if_instr, for early regfile read.
- rf_rs2_addr  out  5  combinational instr[24:20] of if_instr.
- id_valid  out  1  pipeline register holds a valid decoded instruction.
- ex_ready  in  1  execute accepts this cycle.
- id_pc  out  32  registered PC.
- id_opcode  out  7  registered opcode field.
- id_funct3  out  3  registered funct3.
- id_rs1_addr, id_rs2_addr, id_rd_addr  out  5 each  registered register fields.
- id_imm  out  32  registered immediate.
- id_alu_op  out  3  registered ALU op. Encodings: add 000, sll 001, sra 010, sub 011, xor 100, srl 101, or 110, and 111.
- id_cmp  out  1  slt/sltu instruction; execute uses its comparator and funct3.
- id_use_imm  out  1  ALU operand B is id_imm.
- id_rd_we  out  1  writes rd.
- id_illegal  out  1  unrecognised encoding.

Behaviour:
- Reset (rst_n=0, asynchronous): id_valid=0. All other registered outputs are 0.
- Handshake:
  - if_ready = !id_valid | ex_ready | flush (combinational).
  - A transfer in occurs when if_valid & if_ready. A transfer out occurs when id_valid & ex_ready.
- Register update, priority order:
  1. flush: id_valid<=0. The incoming instruction is discarded even if if_valid. Data registers do not care.
  2. Transfer in: all id_* <= decode(if_instr), id_pc<=if_pc, id_valid<=1. This applies even if a simultaneous transfer out occurs (back-to-back, 1 instr/cycle).
  3. Transfer out without transfer in: id_valid<=0.
  4. Otherwise: hold all outputs stable. Outputs never change while id_valid & !ex_ready.
- Latency: 1 cycle from accepted input to id_valid. Full throughput when ex_ready held 1.
- Immediate:
  - I: sext(i[31:20]).
  - S: sext({i[31:25],i[11:7]}).
  - B: sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - U: {i[31:12],12'b0}.
  - J: sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - reg opcode: 0.
- ALU op:
  - Applies to opcodes imm 0010011 and reg 0110011 by funct3.
  - 000: add, or sub if reg & i[30].
  - 001: sll.
  - 010/011: add with id_cmp=1.
  - 100: xor.
  - 101: sra if i[30], else srl.
  - 110: or. 111: and.
  - All other opcodes: add, id_cmp=0.
- id_use_imm=1 for lui, auipc, jal, jalr, load, store, imm. It is 0 for reg and branch.
- id_rd_we=1 for lui, auipc, jal, jalr, load, imm, reg, when rd!=0 and not illegal.
- id_illegal=1 when any of the following holds:
  - opcode not one of the nine RV32I base opcodes.
  - jalr funct3!=000.
  - load funct3 in {011,110,111}.
  - store funct3 >=011.
  - branch funct3 in {010,011}.
  - reg funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101.
  - imm shift (funct3 001/101) with funct7 not 0000000 (or 0100000 for 101).
- An illegal instruction still transfers normally with id_illegal=1, id_rd_we=0.
- Reset mid-stall: the held instruction is lost and id_valid drops immediately (asynchronous).

Test Plan:
- addi x1,x2,-5 (0xFFB10093), pc 0x100, ex_ready=1 -> next cycle: id_valid=1, id_imm=0xFFFFFFFB, rd=1, rs1=2, alu_op=add, use_imm=1, rd_we=1, id_pc=0x100.
- sub x3,x4,x5 (0x405201B3) then srai x6,x7,3 (0x4033D313) back-to-back -> alu_op sub then sra. if_ready stays 1 and there are no bubbles.
- beq with offset -4 (0xFE000EE3) -> id_imm=0xFFFFFFFC, rd_we=0, use_imm=0. jal x1,+2048 (0x001000EF) -> id_imm=0x00000800.
- ex_ready=0 with id_valid=1 and new if_valid -> if_ready=0 and outputs hold for 3 cycles. Raise ex_ready -> next instruction captured the same edge.
- flush asserted while holding an instruction and if_valid=1 -> id_valid=0 next cycle and the incoming instruction is not presented. 0x00000000 -> id_illegal=1, rd_we=0.
- Assert rst_n=0 mid-cycle during a stall -> id_valid=0 immediately, before the clock edge.

Source files
------------

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: one pipeline register, 1-cycle latency, 1 instr/cycle.
// Backpressure: if_ready drops only while a held result is stalled by execute (flush overrides).
module rv32i_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic        id_valid,
  input  logic        ex_ready,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [4:0]  id_rs1_addr,
  output logic [4:0]  id_rs2_addr,
  output logic [4:0]  id_rd_addr,
  output logic [31:0] id_imm,
  output logic [2:0]  id_alu_op,
  output logic        id_cmp,
  output logic        id_use_imm,
  output logic        id_rd_we,
  output logic        id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        cmp;
    logic        use_imm;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  logic [31:0] ins;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        wr;
  dec_t        dec;
  dec_t        dec_d, dec_q;
  logic [31:0] pc_d, pc_q;
  logic        valid_d, valid_q;
  logic        take_in, take_out;

  assign ins = if_instr;
  assign op  = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  assign rf_rs1_addr = ins[19:15];
  assign rf_rs2_addr = ins[24:20];

  always_comb begin
    dec         = '0;
    wr          = 1'b0;
    dec.opcode  = op;
    dec.funct3  = f3;
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.rd      = ins[11:7];
    dec.alu_op  = ALU_ADD;
    case (op)
      OP_LUI, OP_AUIPC: begin
        dec.imm = {ins[31:12], 12'b0};
        dec.use_imm = 1'b1;
        wr = 1'b1;
      end
      OP_JAL: begin
        dec.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        dec.use_imm = 1'b1;
        wr = 1'b1;
      end
      OP_JALR: begin
        dec.imm = {{20{ins[31]}}, ins[31:20]};
        dec.use_imm = 1'b1;
        wr = 1'b1;
        dec.illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        dec.illegal = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec.imm = {{20{ins[31]}}, ins[31:20]};
        dec.use_imm = 1'b1;
        wr = 1'b1;
        dec.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec.use_imm = 1'b1;
        dec.illegal = (f3 >= 3'b011);
      end
      OP_IMM, OP_REG: begin
        if (op == OP_IMM) begin
          dec.imm = {{20{ins[31]}}, ins[31:20]};
          dec.use_imm = 1'b1;
          // Only shift-immediates carry a funct7; everything else is pure immediate.
          dec.illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                        ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        end else begin
          dec.illegal = !((f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        end
        wr = 1'b1;
        case (f3)
          3'b000:         dec.alu_op = ((op == OP_REG) && ins[30]) ? ALU_SUB : ALU_ADD;
          3'b001:         dec.alu_op = ALU_SLL;
          3'b010, 3'b011: dec.cmp    = 1'b1;
          3'b100:         dec.alu_op = ALU_XOR;
          3'b101:         dec.alu_op = ins[30] ? ALU_SRA : ALU_SRL;
          3'b110:         dec.alu_op = ALU_OR;
          default:        dec.alu_op = ALU_AND;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_we = wr && (dec.rd != 5'd0) && !dec.illegal;
  end

  assign if_ready = !valid_q || ex_ready || flush;
  assign take_in  = if_valid && if_ready && !flush;
  assign take_out = valid_q && ex_ready;

  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (take_in) begin
      valid_d = 1'b1;
      dec_d   = dec;
      pc_d    = if_pc;
    end else if (take_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_opcode   = dec_q.opcode;
  assign id_funct3   = dec_q.funct3;
  assign id_rs1_addr = dec_q.rs1;
  assign id_rs2_addr = dec_q.rs2;
  assign id_rd_addr  = dec_q.rd;
  assign id_imm      = dec_q.imm;
  assign id_alu_op   = dec_q.alu_op;
  assign id_cmp      = dec_q.cmp;
  assign id_use_imm  = dec_q.use_imm;
  assign id_rd_we    = dec_q.rd_we;
  assign id_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: scenario tasks drive fetch; a negedge monitor
// scores every instruction handed to execute against hand-decoded expectations.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic        id_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_imm;
  logic [2:0]  id_alu_op;
  logic        id_cmp, id_use_imm, id_rd_we, id_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_imm(id_imm), .id_alu_op(id_alu_op), .id_cmp(id_cmp),
    .id_use_imm(id_use_imm), .id_rd_we(id_rd_we), .id_illegal(id_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  alu;
    logic        cmp;
    logic        use_imm;
    logic        we;
    logic        ill;
  } vec_t;

  logic [95:0] exp_q[$];
  logic [95:0] cur_exp;
  logic [95:0] act;
  vec_t        vecs[24];
  int          nvec;

  assign act = {id_pc, id_opcode, id_funct3, id_rs1_addr, id_rs2_addr, id_rd_addr,
                id_imm, id_alu_op, id_cmp, id_use_imm, id_rd_we, id_illegal};

  function automatic logic [95:0] expect_of(vec_t v, logic [31:0] pc);
    logic [31:0] i;
    i = v.instr;
    return {pc, i[6:0], i[14:12], i[19:15], i[24:20], i[11:7],
            v.imm, v.alu, v.cmp, v.use_imm, v.we, v.ill};
  endfunction

  task automatic drive(input vec_t v, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = v.instr;
    if_pc    = pc;
    cur_exp  = expect_of(v, pc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (id_valid && ex_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got %h, none expected", act);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL out_fields: got %h expected %h", act, e);
          end
        end
      end else if (flush && id_valid && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (if_valid && if_ready && !flush) exp_q.push_back(cur_exp);
    end
  end

  task automatic test_reset;
    checks++;
    if (id_valid !== 1'b0 || act !== 96'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b out=%h expected 0", id_valid, act);
    end
    checks++;
    if (if_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_if_ready: got %b expected 1", if_ready);
    end
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    ex_ready = 1'b1;
    drive(vecs[0], 32'h100);
    checks++;
    if (rf_rs1_addr !== 5'd2 || rf_rs2_addr !== 5'd27) begin
      failures++;
      $display("FAIL rf_addr: got %0d/%0d expected 2/27", rf_rs1_addr, rf_rs2_addr);
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_imm !== 32'hFFFF_FFFB || id_pc !== 32'h100) begin
      failures++;
      $display("FAIL single_latency: valid=%b imm=%h pc=%h expected 1/fffffffb/100",
               id_valid, id_imm, id_pc);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 1; k < nvec; k++) begin
      @(posedge clk); #1;
      drive(vecs[k], 32'h200 + 32'(k * 4));
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_if_ready[%0d]: got %b expected 1", k, if_ready);
      end
      if (k > 1) begin
        checks++;
        if (id_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_bubble[%0d]: id_valid=%b expected 1", k, id_valid);
        end
      end
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last: id_valid=%b expected 1", id_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    logic [95:0] held;
    @(posedge clk); #1;
    ex_ready = 1'b0;
    drive(vecs[1], 32'h300);
    held = cur_exp;
    @(posedge clk); #1;
    drive(vecs[2], 32'h304);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_if_ready[%0d]: got %b expected 0", c, if_ready);
      end
      checks++;
      if (id_valid !== 1'b1 || act !== held) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b got %h expected %h", c, id_valid, act, held);
      end
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: if_ready=%b expected 1", if_ready);
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h304) begin
      failures++;
      $display("FAIL stall_next: valid=%b pc=%h expected 1/304", id_valid, id_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    ex_ready = 1'b0;
    drive(vecs[3], 32'h400);
    @(posedge clk); #1;
    drive(vecs[4], 32'h404);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_if_ready: got %b expected 1", if_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_kill[%0d]: id_valid=%b expected 0", c, id_valid);
      end
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    ex_ready = 1'b0;
    drive(vecs[5], 32'h500);
    @(posedge clk); #1;
    drive(vecs[6], 32'h504);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || act !== 96'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b out=%h expected 0", id_valid, act);
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    nvec = 0;
    //            instr         imm           alu     cmp   use   we    ill
    vecs[nvec++] = {32'hFFB10093, 32'hFFFFFFFB, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // addi x1,x2,-5
    vecs[nvec++] = {32'h405201B3, 32'h00000000, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0}; // sub
    vecs[nvec++] = {32'h4033D313, 32'h00000403, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0}; // srai
    vecs[nvec++] = {32'hFE000EE3, 32'hFFFFFFFC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0}; // beq -4
    vecs[nvec++] = {32'h001000EF, 32'h00000800, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // jal +2048
    vecs[nvec++] = {32'h00000000, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1}; // all zero
    vecs[nvec++] = {32'h12345537, 32'h12345000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // lui
    vecs[nvec++] = {32'h00001117, 32'h00001000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // auipc
    vecs[nvec++] = {32'h00512423, 32'h00000008, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0}; // sw
    vecs[nvec++] = {32'h00412083, 32'h00000004, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // lw
    vecs[nvec++] = {32'h00512093, 32'h00000005, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0}; // slti
    vecs[nvec++] = {32'hFFF17093, 32'hFFFFFFFF, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0}; // andi
    vecs[nvec++] = {32'h007342B3, 32'h00000000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0}; // xor
    vecs[nvec++] = {32'h007352B3, 32'h00000000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0}; // srl
    vecs[nvec++] = {32'h007372B3, 32'h00000000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0}; // and
    vecs[nvec++] = {32'h007312B3, 32'h00000000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0}; // sll
    vecs[nvec++] = {32'h007362B3, 32'h00000000, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0}; // or
    vecs[nvec++] = {32'h007332B3, 32'h00000000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0}; // sltu
    vecs[nvec++] = {32'h00000013, 32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0}; // nop, rd=x0
    vecs[nvec++] = {32'h000110E7, 32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1}; // jalr f3=1
    vecs[nvec++] = {32'h02000033, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1}; // reg f7=1
    vecs[nvec++] = {32'h40311093, 32'h00000403, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1}; // slli bad f7
    vecs[nvec++] = {32'h00002063, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1}; // branch f3=2
    vecs[nvec++] = {32'h00003023, 32'h00000000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1}; // store f3=3

    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_reset();
    test_single();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
